// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random number source with odd/even/range shaping and a
// single-entry valid/ready output slot; range mode falls back to limit after repeated rejections.
module lfsr_rng #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int               MAX_TRIES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    output logic             o_fallback
);

    typedef enum logic [1:0] {
        MODE_RAW   = 2'b00,
        MODE_ODD   = 2'b01,
        MODE_EVEN  = 2'b10,
        MODE_RANGE = 2'b11
    } mode_e;

    localparam logic [3:0] LP_LAST_TRY = 4'(MAX_TRIES - 1);

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_fallback;
    logic [3:0]       r_tries;

    logic             w_fb;
    logic             w_free;
    logic [WIDTH-1:0] w_cand;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_valid_nxt;
    logic             w_fallback_nxt;
    logic [3:0]       w_tries_nxt;
    mode_e            w_mode;

    assign w_mode = mode_e'(i_mode);
    assign w_fb   = ^(r_lfsr & TAPS);
    assign w_free = !r_out_valid || i_out_ready;

    always_comb begin
        w_cand = r_lfsr;
        case (w_mode)
            MODE_ODD:  w_cand = {r_lfsr[WIDTH-1:1], 1'b1};
            MODE_EVEN: w_cand = {r_lfsr[WIDTH-1:1], 1'b0};
            default:   w_cand = r_lfsr;
        endcase
    end

    // Load wins over everything; otherwise the slot only moves when it is free.
    always_comb begin
        w_lfsr_nxt     = r_lfsr;
        w_data_nxt     = r_out_data;
        w_valid_nxt    = r_out_valid;
        w_tries_nxt    = r_tries;
        w_fallback_nxt = 1'b0;

        if (i_load) begin
            w_lfsr_nxt  = (i_seed == '0) ? SEED : i_seed;
            w_valid_nxt = 1'b0;
            w_tries_nxt = '0;
        end else if (w_free) begin
            w_lfsr_nxt = {r_lfsr[WIDTH-2:0], w_fb};
            if (w_mode != MODE_RANGE || w_cand <= i_limit) begin
                w_data_nxt  = w_cand;
                w_valid_nxt = 1'b1;
                w_tries_nxt = '0;
            end else if (r_tries == LP_LAST_TRY) begin
                w_data_nxt     = i_limit;
                w_valid_nxt    = 1'b1;
                w_fallback_nxt = 1'b1;
                w_tries_nxt    = '0;
            end else begin
                w_valid_nxt = 1'b0;
                w_tries_nxt = r_tries + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr      <= SEED;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_fallback  <= 1'b0;
            r_tries     <= '0;
        end else begin
            r_lfsr      <= w_lfsr_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_fallback  <= w_fallback_nxt;
            r_tries     <= w_tries_nxt;
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_fallback  = r_fallback;

endmodule

// File: doc/lfsr_rng.md
LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning state/output width, legal range 4..16.
REQ-002 The block SHALL have parameter TAPS, default 8'hB8, meaning a WIDTH-bit feedback mask; bit i set means state bit i is XORed into the feedback.
REQ-003 The block SHALL have parameter SEED, default 1, meaning a nonzero WIDTH-bit reset and fallback seed.
REQ-004 The block SHALL have parameter MAX_TRIES, default 4, meaning the consecutive range rejections (range 1..15) before fallback.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 load  input  1  synchronous seed load strobe.
REQ-008 seed  input  WIDTH  value loaded when load=1.
REQ-009 mode  input  2  00 raw, 01 odd, 10 even, 11 range.
REQ-010 limit  input  WIDTH  inclusive upper bound, used in range mode only.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 out_data  output  WIDTH  registered pseudorandom value.
REQ-013 out_valid  output  1  out_data holds an unconsumed value.
REQ-014 fallback  output  1  one-cycle pulse with a value forced to limit after MAX_TRIES rejections.

Function
REQ-015 State register lfsr SHALL be a Fibonacci LFSR: on advance, lfsr <= {lfsr[WIDTH-2:0], fb}, where fb = XOR of lfsr[i] over all i with TAPS[i]=1.
REQ-016 The output slot SHALL be free when out_valid=0 or out_ready=1; lfsr, out_data, out_valid and the try counter SHALL hold when the slot is not free and load=0.
REQ-017 In each cycle with a free slot and load=0, candidate cand SHALL be formed from the current lfsr (pre-advance), and lfsr SHALL advance once.
REQ-018 cand transform: raw = lfsr; odd = {lfsr[W-1:1],1}; even = {lfsr[W-1:1],0}; range = lfsr.
REQ-019 In modes 00/01/10, every candidate SHALL be accepted: out_data <= cand and out_valid <= 1 at that edge, so throughput is one value per cycle with out_ready=1.
REQ-020 In range mode, cand <= limit SHALL be accepted (out_data <= cand, out_valid <= 1, try counter <= 0); cand > limit SHALL be rejected (out_valid <= 0, try counter +1).
REQ-021 The rejection that would make the try counter equal MAX_TRIES SHALL instead set out_data <= limit, out_valid <= 1 and fallback <= 1 for one cycle, and clear the try counter.
REQ-022 The try counter SHALL clear whenever mode != 11 or an accepted value is produced.
REQ-023 A mode or limit change SHALL apply to the next candidate only; a value already held in out_data SHALL be unaffected.
REQ-024 load=1 SHALL override advance and backpressure: lfsr <= seed (or SEED when seed == 0, for lockup avoidance), out_valid <= 0, try counter <= 0, fallback <= 0.
REQ-025 The first candidate after a load SHALL be the loaded value, produced at the next free-slot edge.
REQ-026 lfsr SHALL never hold all-zeros; the only entry path (load of zero) is redirected to SEED per REQ-024.

Reset
REQ-027 While rst_n=0, the block SHALL set asynchronously lfsr=SEED, out_data=0, out_valid=0, fallback=0 and try counter=0.
REQ-028 The first candidate after reset release SHALL be SEED, producing out_valid=1 at the first rising edge after release.
REQ-029 Reset assertion mid-stream SHALL discard any held out_data immediately.

Verification (WIDTH=4, TAPS=4'hC, SEED=1, MAX_TRIES=4)
REQ-030 Reset release, mode=00, out_ready=1 -> out_data 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1 on consecutive cycles (period 15, no 0).
REQ-031 mode=01, out_ready=1 after reset -> 1,3,5,9,3,7,D,B,5,B,7,F,F,D,9,1; every value odd.
REQ-032 mode=11, limit=5 -> accepts 1,2,4; rejects 9 (out_valid=0 one cycle); accepts 3; rejects 6,D,A; accepts 5; rejects B,7,F,E, with E yielding out_data=5 and fallback=1.
REQ-033 Valid value 4 held with out_ready=0 for 3 cycles -> out_data stays 4 and out_valid stays 1; next value 9 appears the cycle after out_ready=1.
REQ-034 load=1 with seed=0 during out_ready=0 -> out_valid=0 next cycle, then out_data=1,2,4...; load=1 with seed=7 -> out_data 7,F,E...
REQ-035 rst_n pulse low mid-stream -> out_valid=0 asynchronously, and the sequence restarts at 1.
